// File: rtl/dag_path_pkg.sv
// Shared state, queue entry and count arithmetic for the DAG path counter.
// Build option: define DAG_PATH_SAT_EN to make count adds saturate.
package dag_path_pkg;

  localparam int MAX_NODE_W = 16;
  localparam int MAX_ACC_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    POP,
    EDGE,
    DONE
  } state_t;

  typedef logic [MAX_ACC_W-1:0] acc_t;

  // Entries are stored at the widest supported size; the
  // unused upper bits are always zero.
  typedef struct packed {
    logic                  valid;
    logic [MAX_NODE_W-1:0] idx;
    acc_t                  val;
  } q_entry_t;

  function automatic acc_t acc_mask(input int unsigned w);
    return {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - w);
  endfunction

  function automatic logic acc_carry(
    input acc_t        a,
    input acc_t        b,
    input int unsigned w
  );
    return |(({1'b0, a} + {1'b0, b}) >> w);
  endfunction

  function automatic acc_t acc_add(
    input acc_t        a,
    input acc_t        b,
    input int unsigned w
  );
`ifdef DAG_PATH_SAT_EN
    if (acc_carry(a, b, w)) return acc_mask(w);
`endif
    return (a + b) & acc_mask(w);
  endfunction

endpackage

// File: rtl/dag_path_queue.sv
// Coalescing ring queue: full-array lookup, merge into a hit,
// push at wr_ptr, pop at rd_ptr.
module dag_path_queue
  import dag_path_pkg::*;
#(
  parameter int NODE_W = 10,
  parameter int ACC_W  = 48,
  parameter int QDEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [NODE_W-1:0] push_idx,
  input  logic [ACC_W-1:0]  push_val,
  input  logic              pop,
  output logic [NODE_W-1:0] head_idx,
  output logic [ACC_W-1:0]  head_val,
  input  logic [NODE_W-1:0] lk_idx,
  output logic              lk_hit,
  input  logic              merge,
  input  logic [ACC_W-1:0]  merge_val,
  output logic              merge_cry,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(QDEPTH);

  q_entry_t      ents [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] hit_ptr;
  acc_t          hit_val;
  acc_t          m_val;

  always_comb begin
    lk_hit  = 1'b0;
    hit_ptr = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (ents[i].valid &&
          ents[i].idx == MAX_NODE_W'(lk_idx)) begin
        lk_hit  = 1'b1;
        hit_ptr = PW'(i);
      end
    end
  end

  assign m_val     = acc_t'(merge_val);
  assign hit_val   = ents[hit_ptr].val;
  assign merge_cry = acc_carry(hit_val, m_val, ACC_W);

  assign head_idx = ents[rd_ptr].idx[NODE_W-1:0];
  assign head_val = ents[rd_ptr].val[ACC_W-1:0];

  assign empty = (wr_ptr == rd_ptr) && !ents[rd_ptr].valid;
  assign full  = (wr_ptr == rd_ptr) &&  ents[rd_ptr].valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ents[i].valid <= 1'b0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ents[i].valid <= 1'b0;
      end
    end else begin
      if (pop) begin
        ents[rd_ptr].valid <= 1'b0;
        rd_ptr             <= rd_ptr + 1'b1;
      end
      if (merge) begin
        ents[hit_ptr].val <= acc_add(hit_val, m_val, ACC_W);
      end
      if (push) begin
        ents[wr_ptr].valid <= 1'b1;
        ents[wr_ptr].idx   <= MAX_NODE_W'(push_idx);
        ents[wr_ptr].val   <= acc_t'(push_val);
        wr_ptr             <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dag_path_counter.sv
// Path-count engine over an external adjacency memory, one edge per cycle.
// Build option: DAG_PATH_SAT_EN selects saturating count adds.
module dag_path_counter
  import dag_path_pkg::*;
#(
  parameter int NODE_W = 10,
  parameter int DEG_W  = 4,
  parameter int ACC_W  = 48,
  parameter int QDEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_run,
  input  logic [NODE_W-1:0] start_node,
  input  logic [NODE_W-1:0] end_node,
  output logic              mem_rd_en,
  output logic [NODE_W-1:0] mem_node_idx,
  output logic [DEG_W-1:0]  mem_edge_sel,
  input  logic [DEG_W-1:0]  mem_edge_cnt,
  input  logic [NODE_W-1:0] mem_edge_dst,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  path_count,
  output logic              acc_ovf,
  output logic              q_ovf
);

  state_t            state;
  logic [NODE_W-1:0] start_q;
  logic [NODE_W-1:0] end_q;
  logic [NODE_W-1:0] cur_node;
  logic [ACC_W-1:0]  cur_val;
  logic [DEG_W-1:0]  edge_q;

  logic              q_clr;
  logic              q_push;
  logic              q_pop;
  logic              q_merge;
  logic              lk_hit;
  logic              q_full;
  logic              q_empty;
  logic              m_cry;
  logic [NODE_W-1:0] push_idx;
  logic [ACC_W-1:0]  push_val;
  logic [NODE_W-1:0] head_idx;
  logic [ACC_W-1:0]  head_val;

  logic              at_end;
  logic              in_edge;
  logic              more_edges;
  logic              ovf_now;
  logic [ACC_W-1:0]  pc_sum;
  logic              pc_cry;

  assign at_end     = head_idx == end_q;
  assign in_edge    = (state == EDGE) && (mem_edge_cnt != '0);
  assign more_edges = ({1'b0, edge_q} + 1'b1) < {1'b0, mem_edge_cnt};
  assign ovf_now    = in_edge && !lk_hit && q_full;

  assign q_clr   = (state == IDLE) && start_run;
  assign q_pop   = (state == POP) && !q_empty;
  assign q_merge = in_edge && lk_hit;
  assign q_push  = (state == INIT) ||
                   (in_edge && !lk_hit && !q_full);

  assign push_idx = (state == INIT) ? start_q : mem_edge_dst;
  assign push_val = (state == INIT) ? ACC_W'(1) : cur_val;

  assign pc_sum = ACC_W'(acc_add(acc_t'(path_count),
                                 acc_t'(head_val), ACC_W));
  assign pc_cry = acc_carry(acc_t'(path_count),
                            acc_t'(head_val), ACC_W);

  // Memory reads are issued combinationally so the response
  // lands in the very next cycle: one edge per clock.
  assign mem_rd_en = (q_pop && !at_end) ||
                     (in_edge && !ovf_now && more_edges);

  assign mem_node_idx = !mem_rd_en      ? '0       :
                        (state == POP)  ? head_idx : cur_node;

  assign mem_edge_sel = (mem_rd_en && state == EDGE) ?
                        edge_q + 1'b1 : '0;

  dag_path_queue #(
    .NODE_W (NODE_W),
    .ACC_W  (ACC_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (q_clr),
    .push      (q_push),
    .push_idx  (push_idx),
    .push_val  (push_val),
    .pop       (q_pop),
    .head_idx  (head_idx),
    .head_val  (head_val),
    .lk_idx    (mem_edge_dst),
    .lk_hit    (lk_hit),
    .merge     (q_merge),
    .merge_val (cur_val),
    .merge_cry (m_cry),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      path_count <= '0;
      acc_ovf    <= 1'b0;
      q_ovf      <= 1'b0;
      start_q    <= '0;
      end_q      <= '0;
      cur_node   <= '0;
      cur_val    <= '0;
      edge_q     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_run) begin
            start_q    <= start_node;
            end_q      <= end_node;
            path_count <= '0;
            acc_ovf    <= 1'b0;
            q_ovf      <= 1'b0;
            busy       <= 1'b1;
            state      <= INIT;
          end
        end
        INIT: state <= POP;
        POP: begin
          if (q_empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (at_end) begin
            path_count <= pc_sum;
            if (pc_cry) acc_ovf <= 1'b1;
          end else begin
            cur_node <= head_idx;
            cur_val  <= head_val;
            edge_q   <= '0;
            state    <= EDGE;
          end
        end
        EDGE: begin
          if (!in_edge) begin
            state <= POP;
          end else begin
            if (q_merge && m_cry) acc_ovf <= 1'b1;
            if (ovf_now) begin
              q_ovf <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (more_edges) begin
              edge_q <= edge_q + 1'b1;
            end else begin
              state <= POP;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
